// File: rtl/watch_pkg.sv
// Shared definitions for the watch time-chain counters:
// encodings, common moduli and BCD sizing helper.
package watch_pkg;

    localparam int ENC_BIN     = 0;
    localparam int ENC_BCD     = 1;
    localparam int MOD_SEC_MIN = 60;
    localparam int MOD_HOUR    = 24;

    function automatic int bcd_digits(input int width);
        return width / 4;
    endfunction

endpackage

// File: rtl/cnt_bin2bcd.sv
// Combinational binary to packed-BCD converter (double-dabble).
// Digits are packed LS digit first at bits [3:0].
module cnt_bin2bcd #(
    parameter int IW = 6,
    parameter int OW = 8
)(
    input  logic [IW-1:0] bin,
    output logic [OW-1:0] bcd
);

    logic [OW-1:0] t;

    always_comb begin
        t = '0;
        for (int i = IW - 1; i >= 0; i--) begin
            for (int d = 0; d < OW / 4; d++) begin
                if (t[4*d +: 4] >= 4'd5)
                    t[4*d +: 4] = t[4*d +: 4] + 4'd3;
            end
            t = {t[OW-2:0], bin[i]};
        end
        bcd = t;
    end

endmodule

// File: rtl/pulse_mod_cnt.sv
// Modulo-N up/down pulse counter with binary or packed-BCD output,
// wrap pulses and a validated synchronous load port.
module pulse_mod_cnt
    import watch_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MODULUS = MOD_SEC_MIN,
    parameter int BCD     = ENC_BCD
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             pulse,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] data,
    output logic             carry,
    output logic             borrow,
    output logic             load_err
);

    localparam int             CW   = $clog2(MODULUS);
    localparam int             ND   = bcd_digits(WIDTH);
    localparam logic [CW-1:0]  TOP  = CW'(MODULUS - 1);
    localparam logic [WIDTH:0] MODV = (WIDTH + 1)'(MODULUS);

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic [WIDTH-1:0] data_nx;
    logic [WIDTH-1:0] dec;
    logic [3:0]       dig;
    logic             dig_ok;
    logic             ld_ok;
    logic             carry_nx;
    logic             borrow_nx;
    logic             err_nx;

    // A valid BCD value always fits in WIDTH bits, so decode in place.
    always_comb begin
        dec    = '0;
        dig    = '0;
        dig_ok = 1'b1;
        if (BCD == ENC_BCD) begin
            for (int i = ND - 1; i >= 0; i--) begin
                dig = load_value[4*i +: 4];
                if (dig > 4'd9)
                    dig_ok = 1'b0;
                dec = dec * WIDTH'(10) + WIDTH'(dig);
            end
        end else begin
            dec = load_value;
        end
        ld_ok = dig_ok && ({1'b0, dec} < MODV);
    end

    always_comb begin
        cnt_nx    = cnt;
        carry_nx  = 1'b0;
        borrow_nx = 1'b0;
        err_nx    = 1'b0;
        if (load) begin
            if (ld_ok)
                cnt_nx = dec[CW-1:0];
            else
                err_nx = 1'b1;
        end else if (pulse) begin
            if (!down) begin
                if (cnt == TOP) begin
                    cnt_nx   = '0;
                    carry_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end else begin
                if (cnt == '0) begin
                    cnt_nx    = TOP;
                    borrow_nx = 1'b1;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
        end
    end

    generate
        if (BCD == ENC_BCD) begin : g_bcd
            cnt_bin2bcd #(
                .IW (CW),
                .OW (WIDTH)
            ) u_b2b (
                .bin (cnt_nx),
                .bcd (data_nx)
            );
        end else begin : g_bin
            assign data_nx = WIDTH'(cnt_nx);
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            data     <= '0;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            cnt      <= cnt_nx;
            data     <= data_nx;
            carry    <= carry_nx;
            borrow   <= borrow_nx;
            load_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_pulse_mod_cnt.sv
// Scoreboard bench: BCD seconds counter plus binary hours counter,
// with expected values from an integer reference model.
module tb_pulse_mod_cnt;

    typedef struct packed {
        logic [7:0] d;
        logic       c;
        logic       b;
        logic       e;
        logic [4:0] hd;
        logic       hc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       pulse = 1'b0;
    logic       down  = 1'b0;
    logic       load  = 1'b0;
    logic [7:0] load_value = '0;
    logic [7:0] data;
    logic       carry;
    logic       borrow;
    logic       load_err;

    logic       hpulse = 1'b0;
    logic       hdown  = 1'b0;
    logic       hload  = 1'b0;
    logic [4:0] hlv    = '0;
    logic [4:0] hdata;
    logic       hcarry;
    logic       hborrow;
    logic       hload_err;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   m     = 0;
    int   h     = 0;
    int   ncar  = 0;
    exp_t sbq[$];

    always #5 clock = ~clock;

    pulse_mod_cnt u_dut (
        .clock      (clock),
        .reset      (reset),
        .pulse      (pulse),
        .down       (down),
        .load       (load),
        .load_value (load_value),
        .data       (data),
        .carry      (carry),
        .borrow     (borrow),
        .load_err   (load_err)
    );

    pulse_mod_cnt #(
        .WIDTH   (5),
        .MODULUS (24),
        .BCD     (0)
    ) u_hr (
        .clock      (clock),
        .reset      (reset),
        .pulse      (hpulse),
        .down       (hdown),
        .load       (hload),
        .load_value (hlv),
        .data       (hdata),
        .carry      (hcarry),
        .borrow     (hborrow),
        .load_err   (hload_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] enc(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic step(input logic p, input logic dn, input logic l,
                        input logic [7:0] lv, input logic hp);
        exp_t x;
        exp_t y;
        int   dv;
        bit   ok;
        pulse      = p;
        down       = dn;
        load       = l;
        load_value = lv;
        hpulse     = hp;
        x = '0;
        if (l) begin
            dv = int'(lv[7:4]) * 10 + int'(lv[3:0]);
            ok = (lv[7:4] <= 4'd9) && (lv[3:0] <= 4'd9) && (dv < 60);
            if (ok) m = dv;
            else x.e = 1'b1;
        end else if (p) begin
            if (!dn) begin
                if (m == 59) begin m = 0; x.c = 1'b1; end
                else m = m + 1;
            end else begin
                if (m == 0) begin m = 59; x.b = 1'b1; end
                else m = m - 1;
            end
        end
        if (hp) begin
            if (h == 23) begin h = 0; x.hc = 1'b1; end
            else h = h + 1;
        end
        x.d  = enc(m);
        x.hd = 5'(h);
        sbq.push_back(x);
        @(posedge clock);
        #1;
        chk("sbq_size", 32'(sbq.size()), 32'd1);
        if (sbq.size() > 0) begin
            y = sbq.pop_front();
            chk("data", {24'd0, data}, {24'd0, y.d});
            chk("carry", {31'd0, carry}, {31'd0, y.c});
            chk("borrow", {31'd0, borrow}, {31'd0, y.b});
            chk("load_err", {31'd0, load_err}, {31'd0, y.e});
            chk("hdata", {27'd0, hdata}, {27'd0, y.hd});
            chk("hcarry", {31'd0, hcarry}, {31'd0, y.hc});
        end
    endtask

    initial begin
        repeat (5) @(posedge clock);
        #1;
        chk("rst_data", {24'd0, data}, 32'h00);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        chk("rst_hdata", {27'd0, hdata}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        ncar = 0;
        for (int i = 0; i < 80; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            ncar += int'(carry);
        end
        chk("up_final", {24'd0, data}, 32'h20);
        chk("up_ncarry", 32'(ncar), 32'd1);

        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("hold_data", {24'd0, data}, 32'h20);

        step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("down_final", {24'd0, data}, 32'h57);

        step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h60, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h45, 1'b0);
        chk("load45", {24'd0, data}, 32'h45);
        step(1'b1, 1'b0, 1'b1, 8'h59, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        ncar = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            ncar += int'(hcarry);
        end
        chk("hr_final", {27'd0, hdata}, 32'd6);
        chk("hr_ncarry", 32'(ncar), 32'd1);

        step(1'b0, 1'b0, 1'b1, 8'h37, 1'b0);
        pulse = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("async_data", {24'd0, data}, 32'h00);
        chk("async_hdata", {27'd0, hdata}, 32'd0);
        chk("async_carry", {31'd0, carry}, 32'd0);
        m = 0;
        h = 0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("resume", {24'd0, data}, 32'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
